// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: SRAM-like en/addr_ok/data_ok requests become
// single-beat AXI4 reads, with one read outstanding at a time.
module inst_axi_rd_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    // Fetch-side request: addr_ok accepts a request, data_ok returns it.
    input  logic        inst_sram_en,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_bus_err,
    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // FSM state, exposed for observation
    output logic [1:0]  dbg_state_o
);

    // Handshake rule on both AXI channels: a beat transfers on a rising edge
    // where valid && ready; the master holds valid and payload until then.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // The bridge is read-only; the write flag is accepted but never used.
    logic unused_wr;
    assign unused_wr = inst_sram_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            araddr_q <= 32'd0;
            arsize_q <= 2'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inst_sram_en) begin
                        araddr_q <= inst_sram_addr;
                        arsize_q <= inst_sram_size;
                        state_q  <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) state_q <= S_R;
                end
                S_R: begin
                    // Beats with a foreign ID are consumed (rready=1) and dropped.
                    if (rvalid && (rid == ARID_VAL)) begin
                        rdata_q <= rdata;
                        err_q   <= (rresp != 2'b00) || !rlast;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // addr_ok is forced low during reset even though the state reads IDLE.
    assign inst_sram_addr_ok = (state_q == S_IDLE) && inst_sram_en && !reset;
    assign inst_sram_data_ok = (state_q == S_DONE);
    assign inst_bus_err      = (state_q == S_DONE) && err_q;
    assign inst_sram_rdata   = rdata_q;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);

    assign dbg_state_o = state_q;

endmodule
